// File: rtl/seg7_pkg.sv
// Shared glyph table and segment bit order for the seven-segment driver and
// its capture counterpart, so the encoder and decoder cannot drift apart.
package seg7_pkg;

  localparam int SEG_W = 7;

  typedef enum int unsigned {
    SEG_A = 0, SEG_B = 1, SEG_C = 2, SEG_D = 3, SEG_E = 4, SEG_F = 5, SEG_G = 6
  } seg_bit_e;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t GLYPH_0     = 7'h3F;
  localparam seg_t GLYPH_1     = 7'h06;
  localparam seg_t GLYPH_2     = 7'h5B;
  localparam seg_t GLYPH_3     = 7'h4F;
  localparam seg_t GLYPH_4     = 7'h66;
  localparam seg_t GLYPH_5     = 7'h6D;
  localparam seg_t GLYPH_6     = 7'h7D;
  localparam seg_t GLYPH_7     = 7'h07;
  localparam seg_t GLYPH_8     = 7'h7F;
  localparam seg_t GLYPH_9     = 7'h6F;
  localparam seg_t GLYPH_A     = 7'h77;
  localparam seg_t GLYPH_B     = 7'h7C;
  localparam seg_t GLYPH_C     = 7'h39;
  localparam seg_t GLYPH_D     = 7'h5E;
  localparam seg_t GLYPH_E     = 7'h79;
  localparam seg_t GLYPH_F     = 7'h71;
  localparam seg_t GLYPH_BLANK = 7'h00;

  typedef struct packed {
    logic [3:0] value;
    logic       is_blank;
    logic       is_valid;
  } glyph_dec_t;

  function automatic seg_t seg7_encode(input logic [3:0] value);
    case (value)
      4'h0: return GLYPH_0;
      4'h1: return GLYPH_1;
      4'h2: return GLYPH_2;
      4'h3: return GLYPH_3;
      4'h4: return GLYPH_4;
      4'h5: return GLYPH_5;
      4'h6: return GLYPH_6;
      4'h7: return GLYPH_7;
      4'h8: return GLYPH_8;
      4'h9: return GLYPH_9;
      4'hA: return GLYPH_A;
      4'hB: return GLYPH_B;
      4'hC: return GLYPH_C;
      4'hD: return GLYPH_D;
      4'hE: return GLYPH_E;
      default: return GLYPH_F;
    endcase
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational inverse of seg7_encode: maps an active-high gfedcba pattern
// back to its hex value, flagging the all-off blank and unrecognized glyphs.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  seg_t       pattern,
  output glyph_dec_t dec
);

  always_comb begin
    // NOTE: assign every field before the search so no path leaves dec unassigned (no latch).
    dec = '0;
    for (int v = 0; v < 16; v++) begin
      if (pattern == seg7_encode(4'(v))) begin
        dec.value    = 4'(v);
        dec.is_valid = 1'b1;
      end
    end
    dec.is_blank = (pattern == GLYPH_BLANK);
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs per-digit hex values from a scanned seven-segment bus, with
// stability filtering, per-frame completion pulse and a stale-display timeout.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 262143,
  parameter bit SEG_ACT_LOW    = 1'b1,
  parameter bit DIG_ACT_LOW    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_in,
  input  logic                    err_clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_valid,
  output logic                    code_error,
  output logic                    stale
);

  localparam int          IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [17:0] TIMEOUT_MAX = 18'(TIMEOUT_CYCLES);

  seg_t                  seg_meta, seg_sync, seg_norm, ref_pat;
  logic [NUM_DIGITS-1:0] dig_meta, dig_sync, dig_norm, cap_hot, frame_mask, mask_next;
  logic [IDX_W-1:0]      sel_idx, ref_idx;
  logic                  sel_hot, ref_valid, same_pair, capture, frame_done;
  logic [7:0]            stab_cnt;
  logic [17:0]           tmo_cnt;
  glyph_dec_t            dec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_meta <= '0;
      seg_sync <= '0;
      dig_meta <= '0;
      dig_sync <= '0;
    end else begin
      // NOTE: non-blocking so each stage takes the previous stage's old value.
      seg_meta <= seg_in;
      seg_sync <= seg_meta;
      dig_meta <= dig_in;
      dig_sync <= dig_meta;
    end
  end

  assign seg_norm = SEG_ACT_LOW ? ~seg_sync : seg_sync;
  assign dig_norm = DIG_ACT_LOW ? ~dig_sync : dig_sync;

  always_comb begin
    sel_idx = '0;
    sel_hot = $onehot(dig_norm);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_norm[i]) sel_idx = IDX_W'(i);
    end
  end

  assign same_pair = sel_hot && ref_valid && (sel_idx == ref_idx) && (seg_norm == ref_pat);
  // Fires only on the step into STABLE_MAX, so a held pattern captures once.
  assign capture   = same_pair && (stab_cnt == STABLE_MAX - 8'd1);
  assign cap_hot   = capture ? dig_norm : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_valid <= 1'b0;
      ref_idx   <= '0;
      ref_pat   <= '0;
      stab_cnt  <= '0;
    end else begin
      ref_valid <= sel_hot;
      ref_idx   <= sel_idx;
      ref_pat   <= seg_norm;
      if (!sel_hot)                    stab_cnt <= '0;
      else if (!same_pair)             stab_cnt <= 8'd1;
      else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + 8'd1;
    end
  end

  seg7_glyph_decode u_decode (
    .pattern (seg_norm),
    .dec     (dec)
  );

  assign mask_next  = frame_mask | cap_hot;
  assign frame_done = capture && (&mask_next);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: captured values are reset too; a mid-run reset must read back as zero.
      digits      <= '0;
      digit_blank <= '0;
      frame_mask  <= '0;
      frame_valid <= 1'b0;
      code_error  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_hot[i]) begin
          if (dec.is_valid) begin
            digits[4*i +: 4] <= dec.value;
            digit_blank[i]   <= 1'b0;
          end else if (dec.is_blank) begin
            digit_blank[i]   <= 1'b1;
          end
        end
      end
      frame_valid <= frame_done;
      frame_mask  <= frame_done ? '0 : mask_next;
      if (capture && !dec.is_valid && !dec.is_blank) code_error <= 1'b1;
      else if (err_clear)                            code_error <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                      tmo_cnt <= '0;
    else if (frame_valid)            tmo_cnt <= '0;
    else if (tmo_cnt != TIMEOUT_MAX) tmo_cnt <= tmo_cnt + 18'd1;
  end

  assign stale = (tmo_cnt == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with short stability/timeout settings
// and active-low pins; expectations are hand-derived glyph values.
module tb_seg7_scan_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_in = 4'hF;
  logic        err_clear = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_blank;
  logic        frame_valid, code_error, stale;

  int vectors = 0;
  int miscompares = 0;

  int          fv_count = 0;
  int          two_count = 0;
  logic [15:0] fv_digits = '0;
  logic [15:0] prev_digits = '0;
  logic [3:0]  fv_prev_top = '0;

  seg7_scan_capture #(
    .NUM_DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(64),
    .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .seg_in(seg_in), .dig_in(dig_in),
    .err_clear(err_clear), .digits(digits), .digit_blank(digit_blank),
    .frame_valid(frame_valid), .code_error(code_error), .stale(stale)
  );

  always #5 clock = ~clock;

  // Passive observer: frame pulses and any appearance of value 2 on digit 2.
  always @(negedge clock) begin
    if (frame_valid) begin
      fv_count++;
      fv_digits   = digits;
      fv_prev_top = prev_digits[15:12];
    end
    if (digits[11:8] == 4'h2) two_count++;
    prev_digits = digits;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input int k, input logic [6:0] glyph);
    logic [3:0] one;
    one    = 4'b0001 << k;
    seg_in = ~glyph;
    dig_in = ~one;
  endtask

  task automatic idle();
    seg_in = 7'h7F;
    dig_in = 4'hF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seg_in = 7'(i * 19);
      dig_in = 4'(~(1 << (i % 4)));
      tick();
    end
    vectors++; if (digits !== 16'h0) begin miscompares++; $display("FAIL reset_digits got %h expected %h", digits, 16'h0); end
    vectors++; if (digit_blank !== 4'h0) begin miscompares++; $display("FAIL reset_blank got %h expected %h", digit_blank, 4'h0); end
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_frame_valid got %b expected 0", frame_valid); end
    vectors++; if (code_error !== 1'b0) begin miscompares++; $display("FAIL reset_code_error got %b expected 0", code_error); end
    vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL reset_stale got %b expected 0", stale); end
    idle();
    tick();
    reset = 1'b1;
    hold(3);
    drive(0, 7'h06); hold(10);
    drive(1, 7'h5B); hold(10);
    drive(2, 7'h4F); hold(10);
    drive(3, 7'h66); hold(10);
    idle(); hold(5);
    vectors++; if (digits !== 16'h4321) begin miscompares++; $display("FAIL scan_digits got %h expected %h", digits, 16'h4321); end
    vectors++; if (fv_count !== 1) begin miscompares++; $display("FAIL scan_frame_count got %0d expected 1", fv_count); end
    vectors++; if (fv_digits !== 16'h4321) begin miscompares++; $display("FAIL frame_at_digit3 got %h expected %h", fv_digits, 16'h4321); end
    vectors++; if (fv_prev_top !== 4'h0) begin miscompares++; $display("FAIL frame_coincides got %h expected 0", fv_prev_top); end
  endtask

  task automatic test_glitch();
    int t0;
    drive(2, 7'h7F); hold(10);
    vectors++; if (digits[11:8] !== 4'h8) begin miscompares++; $display("FAIL glitch_preload got %h expected 8", digits[11:8]); end
    t0 = two_count;
    drive(2, 7'h5B); hold(3);
    drive(2, 7'h4F); hold(12);
    idle(); hold(2);
    vectors++; if (two_count !== t0) begin miscompares++; $display("FAIL glitch_rejected got %0d expected %0d", two_count, t0); end
    vectors++; if (digits[11:8] !== 4'h3) begin miscompares++; $display("FAIL glitch_final got %h expected 3", digits[11:8]); end
  endtask

  task automatic test_blank_ghost();
    logic [15:0] d0;
    logic [3:0]  b0;
    int          f0;
    d0 = digits; b0 = digit_blank; f0 = fv_count;
    seg_in = ~7'h71;
    dig_in = ~4'b0011;
    hold(20);
    idle(); hold(2);
    vectors++; if (digits !== d0) begin miscompares++; $display("FAIL ghost_digits got %h expected %h", digits, d0); end
    vectors++; if (digit_blank !== b0) begin miscompares++; $display("FAIL ghost_blank got %h expected %h", digit_blank, b0); end
    vectors++; if (fv_count !== f0) begin miscompares++; $display("FAIL ghost_frame got %0d expected %0d", fv_count, f0); end
    drive(1, 7'h00); hold(10);
    vectors++; if (digit_blank[1] !== 1'b1) begin miscompares++; $display("FAIL blank_set got %b expected 1", digit_blank[1]); end
    vectors++; if (digits[7:4] !== 4'h2) begin miscompares++; $display("FAIL blank_hold got %h expected 2", digits[7:4]); end
    drive(1, 7'h6D); hold(10);
    vectors++; if (digit_blank[1] !== 1'b0) begin miscompares++; $display("FAIL blank_clear got %b expected 0", digit_blank[1]); end
    vectors++; if (digits[7:4] !== 4'h5) begin miscompares++; $display("FAIL blank_newval got %h expected 5", digits[7:4]); end
  endtask

  task automatic test_unknown();
    drive(1, 7'h49); hold(10);
    vectors++; if (code_error !== 1'b1) begin miscompares++; $display("FAIL unknown_sets got %b expected 1", code_error); end
    vectors++; if (digits[7:4] !== 4'h5) begin miscompares++; $display("FAIL unknown_hold got %h expected 5", digits[7:4]); end
    // err_clear is held through the capture edge, 2 + 4 edges after the pin change.
    drive(1, 7'h12);
    err_clear = 1'b1;
    hold(6);
    err_clear = 1'b0;
    hold(6);
    vectors++; if (code_error !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear got %b expected 1", code_error); end
    err_clear = 1'b1; tick();
    err_clear = 1'b0; tick();
    vectors++; if (code_error !== 1'b0) begin miscompares++; $display("FAIL clear_alone got %b expected 0", code_error); end
    vectors++; if ({digit_blank[1], digits[7:4]} !== 5'h05) begin miscompares++; $display("FAIL unknown_digit1 got %h expected 05", {digit_blank[1], digits[7:4]}); end
    idle(); hold(2);
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    vectors++; if (stale !== 1'b1) begin miscompares++; $display("FAIL stale_idle got %b expected 1", stale); end
    drive(0, 7'h7D); hold(10);
    drive(3, 7'h79);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      if (frame_valid) seen = 1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL resume_frame got 0 expected 1"); end
    if (seen) begin
      idle();
      vectors++; if (stale !== 1'b1) begin miscompares++; $display("FAIL stale_at_pulse got %b expected 1", stale); end
      tick();
      vectors++; if (stale !== 1'b0) begin miscompares++; $display("FAIL stale_drop got %b expected 0", stale); end
      // Counter clears one cycle after the pulse, then needs 64 increments.
      n = 1;
      while (!stale && n < 200) begin tick(); n++; end
      vectors++; if (n !== 65) begin miscompares++; $display("FAIL stale_latency got %0d expected 65", n); end
    end
  endtask

  task automatic test_mid_reset();
    int f0;
    drive(0, 7'h07); hold(10);
    drive(1, 7'h6F); hold(10);
    vectors++; if (digits[7:0] !== 8'h97) begin miscompares++; $display("FAIL partial_capture got %h expected 97", digits[7:0]); end
    idle();
    reset = 1'b0;
    #2;
    vectors++; if ({digits, digit_blank, frame_valid, code_error} !== 22'h0) begin miscompares++; $display("FAIL async_reset got %h expected 0", {digits, digit_blank, frame_valid, code_error}); end
    hold(2);
    reset = 1'b1;
    hold(2);
    f0 = fv_count;
    drive(2, 7'h77); hold(10);
    drive(3, 7'h7C); hold(10);
    vectors++; if (fv_count !== f0) begin miscompares++; $display("FAIL partial_discarded got %0d expected %0d", fv_count, f0); end
    drive(0, 7'h39); hold(10);
    drive(1, 7'h5E); hold(10);
    idle(); hold(2);
    vectors++; if (fv_count !== f0 + 1) begin miscompares++; $display("FAIL refill_frame got %0d expected %0d", fv_count, f0 + 1); end
    vectors++; if (digits !== 16'hBADC) begin miscompares++; $display("FAIL refill_digits got %h expected %h", digits, 16'hBADC); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_blank_ghost();
    test_unknown();
    test_timeout();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Samples the scanned segment bus and the one-hot digit-select bus, then reconstructs the value shown on each digit.
- Raises a one-cycle frame pulse once every digit has been refreshed.
- Used in loopback self-test and by a companion board reading the clock's display pins; inputs are treated as asynchronous.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; width of dig_in.
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a digit is captured; legal range 2..255.
- TIMEOUT_CYCLES, 262143: cycles without a completed frame before stale asserts; counter is 18 bits and saturates.
- SEG_ACT_LOW, 1: 1 = a segment is lit when its pin is 0.
- DIG_ACT_LOW, 1: 1 = a digit is selected when its pin is 0.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- seg_in  in  7  segment pins, bit0=a .. bit6=g.
- dig_in  in  NUM_DIGITS  digit-select pins, one-hot when valid.
- err_clear  in  1  synchronous clear of code_error.
- digits  out  4*NUM_DIGITS  captured hex value per digit; digit i occupies [4i+3:4i].
- digit_blank  out  NUM_DIGITS  1 = digit i was last captured with all segments off.
- frame_valid  out  1  one-cycle pulse when all digits have been captured since the last pulse.
- code_error  out  1  sticky; an unrecognized glyph was stable long enough to be captured.
- stale  out  1  no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset values: all outputs 0; synchronizers, stability counter, frame mask and timeout counter all 0. Reset asserted mid-operation clears everything immediately; a partial frame is discarded.
- Input sync: two-flop synchronizer on seg_in and dig_in, then polarity normalization to active-high. Pipeline latency from pin to sample is 2 cycles.
- Select decode:
  - Exactly one dig bit active gives index k.
  - Zero or multiple bits active means "no digit": the stability counter resets to 0 and nothing is captured. This covers ghosting and blanking gaps.
- Stability counter (8 bit):
  - Reference pair is (k, pattern) from the previous sample.
  - Same pair: increment, saturating at STABLE_CYCLES.
  - Different pair: counter loads 1.
  - Capture fires in exactly the one cycle the counter transitions to STABLE_CYCLES, so each held pattern captures once. No recapture until the pair changes.
  - Pin change to capture: 2 + STABLE_CYCLES cycles; outputs update the following cycle.
- Glyph decode, gfedcba hex:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - 00 is blank.
- On capture:
  - Valid glyph: digits[k] takes the value and digit_blank[k] is cleared.
  - Blank: digit_blank[k] is set and digits[k] is held.
  - Unknown glyph: digits[k] and digit_blank[k] are held and code_error is set.
  - All three cases set frame_mask[k].
- Frame completion:
  - When the frame mask including the current capture is all ones, frame_valid pulses for 1 cycle and the mask clears in the same cycle.
  - Recapturing a digit already in the mask has no further effect on the mask.
- code_error: set has priority over a simultaneous err_clear.
- Timeout counter:
  - Cleared by frame_valid; otherwise increments, saturating.
  - stale = 1 while the counter equals TIMEOUT_CYCLES; it drops the cycle after the next frame_valid.
- Widths: the counter compare is unsigned. Parameters outside the legal range are unsupported.

Decomposition:
- Shared package seg7_pkg:
  - the 16 glyph constants and the blank constant;
  - the segment bit-order definition.
  - The display driver must use the same package so encoder and decoder cannot drift.
- Sub-module seg7_glyph_decode: combinational; 7-bit pattern in, {value[3:0], is_blank, is_valid} out.
- Synchronizer, stability counter, frame mask and timeout counter stay in seg7_scan_capture.

Test Plan (bench uses STABLE_CYCLES=4, TIMEOUT_CYCLES=64, active-low pins):
- Reset: hold reset low, toggle pins → all outputs 0. Release, scan digits 0..3 with glyphs 1,2,3,4, 10 cycles each → digits=16'h4321 and exactly one frame_valid, coinciding with the digit-3 capture.
- Glitch rejection: digit 2 shows 5B for 3 cycles, then 4F steady → digits[11:8]=3. The 5B value is never captured.
- Blank/ghost: dig_in with two bits active for 20 cycles → no capture. A single digit with all segments off (pins 7F) → digit_blank set for that digit, value held.
- Unknown glyph: pattern 0x49 held on digit 1 → code_error=1, digits[7:4] unchanged. err_clear asserted in the same cycle as a second bad capture → code_error stays 1; err_clear alone → 0.
- Timeout: stop scanning → stale=1 after 64 cycles. Resume and complete a frame → stale=0 the cycle after frame_valid.
- Mid-frame reset: capture digits 0 and 1, pulse reset, then scan only digits 2 and 3 → no frame_valid until digits 0 and 1 are recaptured.
